// File: rtl/next_hop_selector_pkg.sv
// Shared neighbour-table definitions: field widths, Q2.14 format, packet codes, scan FSM states.
// Imported by the next-hop selector and the Q-table updater.
package next_hop_selector_pkg;

    localparam int NH_WORD_WIDTH = 16;
    localparam int NH_ADDR_WIDTH = 5;

    // Q-values and residual energy are unsigned Q2.14
    localparam int          Q_FRAC_BITS = 14;
    localparam logic [15:0] Q_ONE       = 16'h4000;

    localparam logic [2:0] PKT_TYPE_DATA = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } nh_state_e;

endpackage

// File: rtl/next_hop_selector_if.sv
// Selector <-> neighbour bank / transmit path bundle; slave = selector, master = its environment.
interface next_hop_selector_if
    import next_hop_selector_pkg::*;
#(
    parameter int WORD_WIDTH = NH_WORD_WIDTH,
    parameter int ADDR_WIDTH = NH_ADDR_WIDTH
);
    logic                  en;
    logic [WORD_WIDTH-1:0] neighborCount;
    logic [WORD_WIDTH-1:0] energyThresh;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_WIDTH-1:0] mSourceID;
    logic [WORD_WIDTH-1:0] mSourceHops;
    logic [WORD_WIDTH-1:0] mEnergyLeft;
    logic [WORD_WIDTH-1:0] mQValue;
    logic [WORD_WIDTH-1:0] bestID;
    logic [WORD_WIDTH-1:0] bestHops;
    logic [WORD_WIDTH-1:0] bestQValue;
    logic [ADDR_WIDTH-1:0] bestIndex;
    logic                  found;
    logic                  busy;
    logic                  done;

    modport slave (
        input  en, neighborCount, energyThresh,
        input  mSourceID, mSourceHops, mEnergyLeft, mQValue,
        output rd_en, rd_addr,
        output bestID, bestHops, bestQValue, bestIndex, found, busy, done
    );

    modport master (
        output en, neighborCount, energyThresh,
        output mSourceID, mSourceHops, mEnergyLeft, mQValue,
        input  rd_en, rd_addr,
        input  bestID, bestHops, bestQValue, bestIndex, found, busy, done
    );

endinterface

// File: rtl/next_hop_selector_better_cmp.sv
// Tie-break comparator: replace current best on higher Q, or equal Q with fewer hops. Combinational.
// Also used by cluster-head selection, so it knows nothing about indices.
module nh_better_cmp #(
    parameter int WORD_WIDTH = 16
) (
    input  logic [WORD_WIDTH-1:0] cand_q_i,
    input  logic [WORD_WIDTH-1:0] cand_hops_i,
    input  logic [WORD_WIDTH-1:0] best_q_i,
    input  logic [WORD_WIDTH-1:0] best_hops_i,
    input  logic                  found_i,
    output logic                  replace_o
);

    assign replace_o = !found_i
                    || (cand_q_i > best_q_i)
                    || ((cand_q_i == best_q_i) && (cand_hops_i < best_hops_i));

endmodule

// File: rtl/next_hop_selector.sv
// Scans neighbour entries 0..cnt-1 and keeps the best (Q, then hops, then index); en->done = cnt+2 (1 if cnt==0).
// Starts are ignored unless idle. `NH_ENERGY_FILTER_EN drops entries whose energy is below energyThresh.
module next_hop_selector
    import next_hop_selector_pkg::*;
#(
    parameter int WORD_WIDTH = NH_WORD_WIDTH,
    parameter int ADDR_WIDTH = NH_ADDR_WIDTH
) (
    input logic                 clk,
    input logic                 nrst,
    next_hop_selector_if.slave  bus
);

    localparam int CAP = 1 << ADDR_WIDTH;

    nh_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic                  rd_vld_q;
    logic [ADDR_WIDTH-1:0] rd_idx_q;
    logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
    logic [WORD_WIDTH-1:0] best_hops_q, best_hops_d;
    logic [WORD_WIDTH-1:0] best_qv_q, best_qv_d;
    logic [ADDR_WIDTH-1:0] best_idx_q, best_idx_d;
    logic                  found_q, found_d;
    logic                  replace;
    logic                  eligible;

    nh_better_cmp #(.WORD_WIDTH(WORD_WIDTH)) u_cmp (
        .cand_q_i    (bus.mQValue),
        .cand_hops_i (bus.mSourceHops),
        .best_q_i    (best_qv_q),
        .best_hops_i (best_hops_q),
        .found_i     (found_q),
        .replace_o   (replace)
    );

`ifdef NH_ENERGY_FILTER_EN
    assign eligible = (bus.mEnergyLeft >= bus.energyThresh);
`else
    assign eligible = 1'b1;
    wire unused_energy = ^{bus.mEnergyLeft, bus.energyThresh};
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        best_id_d   = best_id_q;
        best_hops_d = best_hops_q;
        best_qv_d   = best_qv_q;
        best_idx_d  = best_idx_q;
        found_d     = found_q;

        // Compare stage: bank data for the read issued last cycle
        if (rd_vld_q && eligible && replace) begin
            best_id_d   = bus.mSourceID;
            best_hops_d = bus.mSourceHops;
            best_qv_d   = bus.mQValue;
            best_idx_d  = rd_idx_q;
            found_d     = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    best_id_d   = '0;
                    best_hops_d = '0;
                    best_qv_d   = '0;
                    best_idx_d  = '0;
                    found_d     = 1'b0;
                    addr_d      = '0;
                    if (bus.neighborCount >= WORD_WIDTH'(CAP)) begin
                        last_d = '1;
                    end else begin
                        last_d = ADDR_WIDTH'(bus.neighborCount - WORD_WIDTH'(1));
                    end
                    state_d = (bus.neighborCount == '0) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (addr_q == last_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            best_id_q   <= '0;
            best_hops_q <= '0;
            best_qv_q   <= '0;
            best_idx_q  <= '0;
            found_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            rd_vld_q    <= (state_q == ST_SCAN);
            rd_idx_q    <= addr_q;
            best_id_q   <= best_id_d;
            best_hops_q <= best_hops_d;
            best_qv_q   <= best_qv_d;
            best_idx_q  <= best_idx_d;
            found_q     <= found_d;
        end
    end

    assign bus.rd_en      = (state_q == ST_SCAN);
    assign bus.rd_addr    = addr_q;
    assign bus.busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.bestID     = best_id_q;
    assign bus.bestHops   = best_hops_q;
    assign bus.bestQValue = best_qv_q;
    assign bus.bestIndex  = best_idx_q;
    assign bus.found      = found_q;

endmodule

// File: tb/tb_next_hop_selector.sv
// Directed bench for next_hop_selector: bank model with one-cycle read latency, expected results queued at start.
module tb_next_hop_selector;
    import next_hop_selector_pkg::*;

    localparam int WW  = NH_WORD_WIDTH;
    localparam int AW  = NH_ADDR_WIDTH;
    localparam int CAP = 1 << AW;

    typedef struct {
        bit          found;
        int          idx;
        logic [15:0] q;
        logic [15:0] hops;
        logic [15:0] id;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    next_hop_selector_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

    next_hop_selector #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    logic [15:0] q_mem    [CAP];
    logic [15:0] hops_mem [CAP];
    logic [15:0] id_mem   [CAP];
    logic [15:0] en_mem   [CAP];

    int   vectors = 0;
    int   errs    = 0;
    exp_t exp_q[$];
    int   addr_q[$];

    // Bank: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.rd_en === 1'b1) begin
            bus.mQValue     <= q_mem[bus.rd_addr];
            bus.mSourceHops <= hops_mem[bus.rd_addr];
            bus.mSourceID   <= id_mem[bus.rd_addr];
            bus.mEnergyLeft <= en_mem[bus.rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        int ea;
        if (nrst === 1'b0 && bus.rd_en === 1'b1) begin
            ea = (addr_q.size() != 0) ? addr_q.pop_front() : -1;
            chk("rd_addr", 32'(bus.rd_addr), ea);
        end
    end

    function automatic exp_t model(input int n);
        exp_t e;
        int   m;
        bit   ok;
        m = (n > CAP) ? CAP : n;
        e = '{found: 1'b0, idx: 0, q: 16'h0, hops: 16'h0, id: 16'h0, lat: (m == 0) ? 1 : m + 2};
        for (int i = 0; i < m; i++) begin
`ifdef NH_ENERGY_FILTER_EN
            ok = (en_mem[i] >= bus.energyThresh);
`else
            ok = 1'b1;
`endif
            if (ok && (!e.found || q_mem[i] > e.q || (q_mem[i] == e.q && hops_mem[i] < e.hops))) begin
                e.found = 1'b1; e.idx = i; e.q = q_mem[i]; e.hops = hops_mem[i]; e.id = id_mem[i];
            end
        end
        return e;
    endfunction

    task automatic load(input int i, input logic [15:0] q, input logic [15:0] h, input logic [15:0] en);
        q_mem[i] = q; hops_mem[i] = h; en_mem[i] = en; id_mem[i] = 16'h0A00 + 16'(i);
    endtask

    // Returns at the negedge of the done cycle
    task automatic run_scan(input int n, input int mid_en, input exp_t e);
        int   lat;
        bit   seen;
        exp_t x;
        for (int i = 0; i < ((n > CAP) ? CAP : n); i++) addr_q.push_back(i);
        exp_q.push_back(e);
        @(negedge clk);
        bus.neighborCount = 16'(n);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        lat  = 1;
        seen = 1'b0;
        x = exp_q.pop_front();
        chk("busy_first", 32'(bus.busy), 32'(x.lat > 1));
        while (lat < 100) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            bus.en = (lat == mid_en);
            @(negedge clk);
            lat++;
        end
        bus.en = 1'b0;
        chk("latency", seen ? lat : -1, x.lat);
        chk("found", 32'(bus.found), 32'(x.found));
        chk("bestIndex", 32'(bus.bestIndex), x.idx);
        chk("bestQValue", 32'(bus.bestQValue), 32'(x.q));
        chk("bestHops", 32'(bus.bestHops), 32'(x.hops));
        chk("bestID", 32'(bus.bestID), 32'(x.id));
        chk("busy_done", 32'(bus.busy), 0);
    endtask

    initial begin
        exp_t e;
        nrst = 1'b1;
        bus.en = 1'b0;
        bus.neighborCount = '0;
        bus.energyThresh = '0;
        for (int i = 0; i < CAP; i++) load(i, 16'h0, 16'h0, 16'hFFFF);
        repeat (2) @(negedge clk);
        chk("rst_rd_en", 32'(bus.rd_en), 0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_found", 32'(bus.found), 0);
        chk("rst_best", {bus.bestQValue, bus.bestID}, 0);
        nrst = 1'b0;

        // Highest Q wins regardless of hops
        load(0, 16'h3000, 16'd2, 16'hFFFF);
        load(1, 16'h8000, 16'd4, 16'hFFFF);
        load(2, 16'h1000, 16'd1, 16'hFFFF);
        run_scan(3, 0, '{found: 1'b1, idx: 1, q: 16'h8000, hops: 16'd4, id: 16'h0A01, lat: 5});
        // Start on the DONE cycle is dropped; result holds afterwards
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        chk("done_cycle_en_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("hold_found", 32'(bus.found), 1);
        chk("hold_index", 32'(bus.bestIndex), 1);

        // Equal Q: fewer hops, then lower index
        load(0, 16'h4000, 16'd3, 16'hFFFF);
        load(1, 16'h4000, 16'd1, 16'hFFFF);
        run_scan(2, 0, '{found: 1'b1, idx: 1, q: 16'h4000, hops: 16'd1, id: 16'h0A01, lat: 4});
        load(0, 16'h4000, 16'd1, 16'hFFFF);
        run_scan(2, 0, '{found: 1'b1, idx: 0, q: 16'h4000, hops: 16'd1, id: 16'h0A00, lat: 4});

        // Empty table
        run_scan(0, 0, '{found: 1'b0, idx: 0, q: 16'h0, hops: 16'h0, id: 16'h0, lat: 1});
        // Single entry
        run_scan(1, 0, '{found: 1'b1, idx: 0, q: 16'h4000, hops: 16'd1, id: 16'h0A00, lat: 3});

        // Oversized count clamps to full capacity; mid-scan start ignored
        for (int i = 0; i < CAP; i++)
            load(i, 16'($urandom_range(0, 7)) << 12, 16'($urandom_range(0, 7)), 16'hFFFF);
        e = model(40);
        run_scan(40, 10, e);
        chk("cap_latency_const", 32'(e.lat), 34);
        @(negedge clk);
        chk("after_ignored_en", 32'(bus.busy), 0);

        // Reset during the second SCAN cycle
        for (int i = 0; i < 5; i++) addr_q.push_back(i);
        @(negedge clk);
        bus.neighborCount = 16'd5;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        nrst = 1'b0;
        addr_q.delete();
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_rd_en", 32'(bus.rd_en), 0);
        chk("midrst_found", 32'(bus.found), 0);
        for (int k = 0; k < 8; k++) begin
            chk("midrst_no_done", 32'(bus.done), 0);
            @(negedge clk);
        end
        e = model(5);
        run_scan(5, 0, e);

        // Energy filter: low-energy entry with the best Q is skipped only when filtering is built in
        bus.energyThresh = 16'h4000;
        load(0, 16'hC000, 16'd1, 16'h2000);
        load(1, 16'h1000, 16'd1, 16'h6000);
`ifdef NH_ENERGY_FILTER_EN
        run_scan(2, 0, '{found: 1'b1, idx: 1, q: 16'h1000, hops: 16'd1, id: 16'h0A01, lat: 4});
        load(1, 16'h1000, 16'd1, 16'h3FFF);
        run_scan(2, 0, '{found: 1'b0, idx: 0, q: 16'h0, hops: 16'h0, id: 16'h0, lat: 4});
`else
        run_scan(2, 0, '{found: 1'b1, idx: 0, q: 16'hC000, hops: 16'd1, id: 16'h0A00, lat: 4});
`endif

        @(negedge clk);
        chk("addr_queue_drained", addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
